// File: rtl/input_pkg.sv
// Scan codes, joystick bit positions and shared types for the HPS input conditioner.
package input_pkg;

    localparam int unsigned COIN_PULSE_DEFAULT = 1_600_000;

    localparam logic [7:0] KEY_UP       = 8'h75;
    localparam logic [7:0] KEY_DOWN     = 8'h72;
    localparam logic [7:0] KEY_LEFT     = 8'h6B;
    localparam logic [7:0] KEY_RIGHT    = 8'h74;
    localparam logic [7:0] KEY_P1B1     = 8'h14;
    localparam logic [7:0] KEY_P1B2     = 8'h11;
    localparam logic [7:0] KEY_P1B3     = 8'h29;
    localparam logic [7:0] KEY_P1START  = 8'h16;
    localparam logic [7:0] KEY_P2START  = 8'h1E;
    localparam logic [7:0] KEY_P1COIN   = 8'h2E;
    localparam logic [7:0] KEY_P2COIN   = 8'h36;
    localparam logic [7:0] KEY_SVC1     = 8'h46;
    localparam logic [7:0] KEY_SVC2     = 8'h45;
    localparam logic [7:0] KEY_P2B1     = 8'h1C;
    localparam logic [7:0] KEY_P2B2     = 8'h1B;
    localparam logic [7:0] KEY_P2B3     = 8'h15;
    localparam logic [7:0] KEY_P2UP     = 8'h2D;
    localparam logic [7:0] KEY_P2DOWN   = 8'h2B;
    localparam logic [7:0] KEY_P2LEFT   = 8'h23;
    localparam logic [7:0] KEY_P2RIGHT  = 8'h34;
    localparam logic [7:0] KEY_P        = 8'h4D;

    localparam int unsigned JOY_RIGHT = 0;
    localparam int unsigned JOY_LEFT  = 1;
    localparam int unsigned JOY_DOWN  = 2;
    localparam int unsigned JOY_UP    = 3;
    localparam int unsigned JOY_B1    = 4;
    localparam int unsigned JOY_B2    = 5;
    localparam int unsigned JOY_B3    = 6;
    localparam int unsigned JOY_START = 7;
    localparam int unsigned JOY_COIN  = 8;
    localparam int unsigned JOY_PAUSE = 9;

    typedef struct packed {
        logic       service;
        logic       pause;
        logic       coin;
        logic       start;
        logic [2:0] buttons;
        logic       up;
        logic       down;
        logic       left;
        logic       right;
    } ctrl_t;

endpackage

// File: rtl/input_conditioner_if.sv
// Raw HPS inputs and conditioned player controls between hps_io and Main.
interface input_conditioner_if;
    logic [10:0] ps2_key;
    logic [10:0] joystick_0;
    logic [10:0] joystick_1;
    logic        player1_up, player1_down, player1_left, player1_right;
    logic        player2_up, player2_down, player2_left, player2_right;
    logic [2:0]  player1_buttons, player2_buttons;
    logic        player1_start, player2_start;
    logic        player1_coin, player2_coin;
    logic        player1_pause, player2_pause;
    logic        service1, service2;

    modport master (
        output ps2_key, joystick_0, joystick_1,
        input  player1_up, player1_down, player1_left, player1_right,
        input  player2_up, player2_down, player2_left, player2_right,
        input  player1_buttons, player2_buttons, player1_start, player2_start,
        input  player1_coin, player2_coin, player1_pause, player2_pause,
        input  service1, service2
    );

    modport slave (
        input  ps2_key, joystick_0, joystick_1,
        output player1_up, player1_down, player1_left, player1_right,
        output player2_up, player2_down, player2_left, player2_right,
        output player1_buttons, player2_buttons, player1_start, player2_start,
        output player1_coin, player2_coin, player1_pause, player2_pause,
        output service1, service2
    );
endinterface

// File: rtl/pulse_stretcher.sv
// Holds a pulse high for at least LENGTH+1 cycles; edges during a stretch are ignored.
module pulse_stretcher #(
    parameter int unsigned LENGTH = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic in,
    output logic out
);
    localparam int unsigned CntW = $clog2(LENGTH + 1);

    logic            in_q;
    logic [CntW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (in && !in_q && (count_q == '0)) begin
            count_d = CntW'(LENGTH);
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            in_q    <= 1'b0;
            count_q <= '0;
        end else begin
            in_q    <= in;
            count_q <= count_d;
        end
    end

    assign out = in | (count_q != '0);

endmodule

// File: rtl/input_conditioner.sv
// Decodes PS/2 key events, merges them with joystick words and conditions the player controls.
module input_conditioner
    import input_pkg::*;
#(
    parameter int unsigned COIN_PULSE = COIN_PULSE_DEFAULT
) (
    input logic                clock,
    input logic                reset,
    input_conditioner_if.slave bus
);
    logic             toggle_q;
    ctrl_t [1:0]      key_q, key_d;
    ctrl_t [1:0]      joy_c;
    ctrl_t [1:0]      raw_q, raw_d;
    ctrl_t [1:0]      out_q, out_d;
    logic  [1:0]      pause_prev_q;
    logic  [1:0]      coin_stretched;
    logic  [1:0][10:0] joy;
    logic             key_event, pressed;
    logic             unused_bits;

    assign joy         = {bus.joystick_1, bus.joystick_0};
    assign key_event   = bus.ps2_key[10] != toggle_q;
    assign pressed     = bus.ps2_key[9];
    assign unused_bits = ^{bus.ps2_key[8], bus.joystick_0[10], bus.joystick_1[10]};

    always_comb begin
        key_d = key_q;
        if (key_event) begin
            case (bus.ps2_key[7:0])
                KEY_UP:      key_d[0].up         = pressed;
                KEY_DOWN:    key_d[0].down       = pressed;
                KEY_LEFT:    key_d[0].left       = pressed;
                KEY_RIGHT:   key_d[0].right      = pressed;
                KEY_P1B1:    key_d[0].buttons[0] = pressed;
                KEY_P1B2:    key_d[0].buttons[1] = pressed;
                KEY_P1B3:    key_d[0].buttons[2] = pressed;
                KEY_P1START: key_d[0].start      = pressed;
                KEY_P2START: key_d[1].start      = pressed;
                KEY_P1COIN:  key_d[0].coin       = pressed;
                KEY_P2COIN:  key_d[1].coin       = pressed;
                KEY_SVC1:    key_d[0].service    = pressed;
                KEY_SVC2:    key_d[1].service    = pressed;
                KEY_P2B1:    key_d[1].buttons[0] = pressed;
                KEY_P2B2:    key_d[1].buttons[1] = pressed;
                KEY_P2B3:    key_d[1].buttons[2] = pressed;
                KEY_P2UP:    key_d[1].up         = pressed;
                KEY_P2DOWN:  key_d[1].down       = pressed;
                KEY_P2LEFT:  key_d[1].left       = pressed;
                KEY_P2RIGHT: key_d[1].right      = pressed;
                KEY_P:       key_d[0].pause      = pressed;
                default: ;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            joy_c[i]         = '0;
            joy_c[i].right   = joy[i][JOY_RIGHT];
            joy_c[i].left    = joy[i][JOY_LEFT];
            joy_c[i].down    = joy[i][JOY_DOWN];
            joy_c[i].up      = joy[i][JOY_UP];
            joy_c[i].buttons = {joy[i][JOY_B3], joy[i][JOY_B2], joy[i][JOY_B1]};
            joy_c[i].start   = joy[i][JOY_START];
            joy_c[i].coin    = joy[i][JOY_COIN];
            joy_c[i].pause   = joy[i][JOY_PAUSE];
            raw_d[i]         = key_q[i] | joy_c[i];
        end
    end

    pulse_stretcher #(.LENGTH(COIN_PULSE)) u_coin1 (
        .clock (clock),
        .reset (reset),
        .in    (raw_q[0].coin),
        .out   (coin_stretched[0])
    );

    pulse_stretcher #(.LENGTH(COIN_PULSE)) u_coin2 (
        .clock (clock),
        .reset (reset),
        .in    (raw_q[1].coin),
        .out   (coin_stretched[1])
    );

    // The pause field of out_q is the latch itself, so it toggles straight off the raw edge.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            out_d[i]       = raw_q[i];
            out_d[i].up    = raw_q[i].up & ~raw_q[i].down;
            out_d[i].down  = raw_q[i].down & ~raw_q[i].up;
            out_d[i].left  = raw_q[i].left & ~raw_q[i].right;
            out_d[i].right = raw_q[i].right & ~raw_q[i].left;
            out_d[i].coin  = coin_stretched[i];
            out_d[i].pause = out_q[i].pause ^ (raw_q[i].pause & ~pause_prev_q[i]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            toggle_q     <= 1'b0;
            key_q        <= '0;
            raw_q        <= '0;
            out_q        <= '0;
            pause_prev_q <= '0;
        end else begin
            toggle_q     <= bus.ps2_key[10];
            key_q        <= key_d;
            raw_q        <= raw_d;
            out_q        <= out_d;
            pause_prev_q <= {raw_q[1].pause, raw_q[0].pause};
        end
    end

    assign bus.player1_up      = out_q[0].up;
    assign bus.player1_down    = out_q[0].down;
    assign bus.player1_left    = out_q[0].left;
    assign bus.player1_right   = out_q[0].right;
    assign bus.player1_buttons = out_q[0].buttons;
    assign bus.player1_start   = out_q[0].start;
    assign bus.player1_coin    = out_q[0].coin;
    assign bus.player1_pause   = out_q[0].pause;
    assign bus.service1        = out_q[0].service;
    assign bus.player2_up      = out_q[1].up;
    assign bus.player2_down    = out_q[1].down;
    assign bus.player2_left    = out_q[1].left;
    assign bus.player2_right   = out_q[1].right;
    assign bus.player2_buttons = out_q[1].buttons;
    assign bus.player2_start   = out_q[1].start;
    assign bus.player2_coin    = out_q[1].coin;
    assign bus.player2_pause   = out_q[1].pause;
    assign bus.service2        = out_q[1].service;

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench: a cycle-level reference model queues expected controls, a monitor compares.
module tb_input_conditioner;
    localparam int L = 8;

    logic clk = 1'b0;
    logic reset;
    input_conditioner_if bus_if();

    input_conditioner #(.COIN_PULSE(L)) dut (
        .clock (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic mon_on = 1'b1;
    logic [21:0] exp_q[$];

    // Control vector layout: bit 0..9 as the joystick word, bit 10 = service.
    logic [10:0] keys [2];
    logic [10:0] lvl_cur [2];
    logic [10:0] lvl_prev [2];
    logic        pause_l [2];
    int          st_lo [2];
    int          st_hi [2];
    logic        last_tog;
    int          cyc = 0;
    logic [10:0] e [2];
    logic [10:0] lc, lp;
    logic        act;
    int          hit;

    function automatic int key_lookup(input logic [7:0] code);
        case (code)
            8'h75: return 3;        8'h72: return 2;
            8'h6B: return 1;        8'h74: return 0;
            8'h14: return 4;        8'h11: return 5;        8'h29: return 6;
            8'h16: return 7;        8'h1E: return 16 + 7;
            8'h2E: return 8;        8'h36: return 16 + 8;
            8'h46: return 10;       8'h45: return 16 + 10;
            8'h1C: return 16 + 4;   8'h1B: return 16 + 5;   8'h15: return 16 + 6;
            8'h2D: return 16 + 3;   8'h2B: return 16 + 2;
            8'h23: return 16 + 1;   8'h34: return 16 + 0;
            8'h4D: return 9;
            default: return -1;
        endcase
    endfunction

    // Reference model: output at this edge is the conditioned merged level of the previous cycle.
    always @(posedge clk) begin
        if (reset) begin
            for (int p = 0; p < 2; p++) begin
                keys[p] = '0; lvl_cur[p] = '0; lvl_prev[p] = '0;
                pause_l[p] = 1'b0; st_lo[p] = 0; st_hi[p] = -1;
            end
            last_tog = 1'b0;
            exp_q.push_back('0);
        end else begin
            for (int p = 0; p < 2; p++) begin
                lc = lvl_cur[p];
                lp = lvl_prev[p];
                e[p] = lc & 11'h4F0;
                e[p][3] = lc[3] & ~lc[2];
                e[p][2] = lc[2] & ~lc[3];
                e[p][1] = lc[1] & ~lc[0];
                e[p][0] = lc[0] & ~lc[1];
                act = (cyc - 1 >= st_lo[p]) && (cyc - 1 <= st_hi[p]);
                if (lc[8] && !lp[8] && !act) begin
                    st_lo[p] = cyc;
                    st_hi[p] = cyc - 1 + L;
                end
                e[p][8] = lc[8] | act;
                if (lc[9] && !lp[9]) pause_l[p] = ~pause_l[p];
                e[p][9] = pause_l[p];
            end
            exp_q.push_back({e[1], e[0]});
            lvl_prev[0] = lvl_cur[0];
            lvl_prev[1] = lvl_cur[1];
            lvl_cur[0] = keys[0] | {1'b0, bus_if.joystick_0[9:0]};
            lvl_cur[1] = keys[1] | {1'b0, bus_if.joystick_1[9:0]};
            if (bus_if.ps2_key[10] != last_tog) begin
                hit = key_lookup(bus_if.ps2_key[7:0]);
                if (hit >= 0) keys[hit / 16][hit % 16] = bus_if.ps2_key[9];
            end
            last_tog = bus_if.ps2_key[10];
        end
        cyc++;
    end

    logic [21:0] got, want;
    always @(negedge clk) begin
        if (mon_on) begin
            got = {bus_if.service2, bus_if.player2_pause, bus_if.player2_coin,
                   bus_if.player2_start, bus_if.player2_buttons, bus_if.player2_up,
                   bus_if.player2_down, bus_if.player2_left, bus_if.player2_right,
                   bus_if.service1, bus_if.player1_pause, bus_if.player1_coin,
                   bus_if.player1_start, bus_if.player1_buttons, bus_if.player1_up,
                   bus_if.player1_down, bus_if.player1_left, bus_if.player1_right};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_empty t=%0t got=%h required=an expected entry", $time,
                         got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    failures++;
                    $display("FAIL outputs t=%0t got=%h required=%h", $time, got, want);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic key(input logic [7:0] code, input logic pr);
        bus_if.ps2_key = {~bus_if.ps2_key[10], pr, 1'b0, code};
        @(negedge clk);
    endtask

    logic [7:0] codes [24] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h14, 8'h11, 8'h29, 8'h16,
                               8'h1E, 8'h2E, 8'h36, 8'h46, 8'h45, 8'h1C, 8'h1B, 8'h15,
                               8'h2D, 8'h2B, 8'h23, 8'h34, 8'h4D, 8'h99, 8'h00, 8'hF0};

    initial begin
        reset = 1'b1;
        bus_if.ps2_key = '0;
        bus_if.joystick_0 = '0;
        bus_if.joystick_1 = '0;
        idle(3);
        reset = 1'b0;
        idle(2);
        // Key decode and an unmapped code
        key(8'h75, 1'b1); idle(5);
        key(8'h75, 1'b0); idle(5);
        key(8'h99, 1'b1); idle(5);
        // Direction cancellation
        bus_if.joystick_0 = 11'h00C; idle(4);
        bus_if.joystick_0 = 11'h008; idle(4);
        bus_if.joystick_0 = 11'h00B; idle(4);
        bus_if.joystick_0 = '0; idle(3);
        // Coin stretch: single pulse, retrigger inside stretch, long hold
        bus_if.joystick_1[8] = 1'b1; idle(1);
        bus_if.joystick_1[8] = 1'b0; idle(2);
        bus_if.joystick_1[8] = 1'b1; idle(1);
        bus_if.joystick_1[8] = 1'b0; idle(12);
        bus_if.joystick_1[8] = 1'b1; idle(20);
        bus_if.joystick_1[8] = 1'b0; idle(12);
        // Pause toggle by key and by joystick
        key(8'h4D, 1'b1); idle(10);
        key(8'h4D, 1'b0); idle(3);
        key(8'h4D, 1'b1); idle(3);
        key(8'h4D, 1'b0); idle(3);
        bus_if.joystick_1[9] = 1'b1; idle(1);
        bus_if.joystick_1[9] = 1'b0; idle(3);
        bus_if.joystick_1[9] = 1'b1; idle(2);
        bus_if.joystick_1[9] = 1'b0; idle(4);
        // Reset mid-stretch, while paused, with a key held
        key(8'h4D, 1'b1); key(8'h4D, 1'b0);
        key(8'h75, 1'b1);
        bus_if.joystick_1[8] = 1'b1; idle(1);
        bus_if.joystick_1[8] = 1'b0; idle(3);
        reset = 1'b1; idle(1);
        reset = 1'b0; idle(6);
        // Back-to-back key events
        key(8'h16, 1'b1); key(8'h1E, 1'b1); idle(5);
        key(8'h16, 1'b0); key(8'h1E, 1'b0); idle(5);
        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(7) == 0) begin
                bus_if.ps2_key = {~bus_if.ps2_key[10], 1'($urandom_range(1)),
                                  1'($urandom_range(1)), codes[$urandom_range(23)]};
            end
            if ($urandom_range(3) == 0)
                bus_if.joystick_0[$urandom_range(10)] ^= 1'b1;
            if ($urandom_range(3) == 0)
                bus_if.joystick_1[$urandom_range(10)] ^= 1'b1;
            reset = ($urandom_range(299) == 0);
            idle(1);
        end
        reset = 1'b0;
        idle(6);
        mon_on = 1'b0;
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
